// File: rtl/shared_mem_model_if.sv
// Request/response bundle between requester channels and the shared line memory model.
// Channel i occupies bit i of the per-channel vectors and slice i of the packed buses.
interface shared_mem_model_if #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic [NCH-1:0]        req_valid;
    logic [NCH-1:0]        req_ready;
    logic [NCH-1:0]        req_wr;
    logic [NCH*ADDR_W-1:0] req_addr;
    logic [NCH*LINE_W-1:0] req_wdata;
    logic [NCH-1:0]        rsp_valid;
    logic [NCH-1:0]        rsp_wr;
    logic [NCH*LINE_W-1:0] rsp_rdata;
    logic                  busy;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_wr, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_wr, rsp_rdata, busy
    );
endinterface

// File: rtl/shared_mem_model.sv
// Multi-channel shared line memory with round-robin grant and fixed-latency responses.
// Define SHARED_MEM_MODEL_SCRAMBLE_EN to make never-written lines read as a DEADBEEF pattern.
module shared_mem_model #(
    parameter int NCH       = 2,
    parameter int ADDR_W    = 32,
    parameter int LINE_W    = 128,
    parameter int DEPTH_LG2 = 8,
    parameter int LATENCY   = 5
) (
    input logic              clk,
    input logic              reset,
    shared_mem_model_if.slave bus
);
    localparam int PTR_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int NLINES = 1 << DEPTH_LG2;

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic [NCH-1:0]    ch;
        logic [LINE_W-1:0] data;
    } entry_t;

    logic [LINE_W-1:0]    mem [NLINES];
    logic [NLINES-1:0]    written;
    logic [PTR_W-1:0]     ptr;
    entry_t               pipe [LATENCY];

    logic [NCH-1:0]       grant;
    logic [PTR_W-1:0]     gnt_idx;
    logic [PTR_W-1:0]     cand;
    logic                 gnt_any;

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = PTR_W'((int'(ptr) + k) % NCH);
            if (!reset && !gnt_any && bus.req_valid[cand]) begin
                gnt_any     = 1'b1;
                gnt_idx     = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    logic [ADDR_W-1:0]    sel_addr;
    logic [LINE_W-1:0]    sel_wdata;
    logic                 sel_wr;
    logic [DEPTH_LG2-1:0] line_idx;
    logic [LINE_W-1:0]    unwritten_line;
    logic [LINE_W-1:0]    read_line;
    logic                 unused_addr_bits;

    assign sel_addr  = bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign sel_wdata = bus.req_wdata[gnt_idx*LINE_W +: LINE_W];
    assign sel_wr    = bus.req_wr[gnt_idx];
    assign line_idx  = sel_addr[DEPTH_LG2+3:4];
    assign unused_addr_bits = ^{sel_addr[ADDR_W-1:DEPTH_LG2+4], sel_addr[3:0]};

`ifdef SHARED_MEM_MODEL_SCRAMBLE_EN
    assign unwritten_line = {(LINE_W/32){32'hDEADBEEF ^ 32'(line_idx)}};
`else
    assign unwritten_line = '0;
`endif

    // Only one grant per cycle, so a read always sees every earlier-granted write already in mem.
    assign read_line = written[line_idx] ? mem[line_idx] : unwritten_line;

    entry_t new_entry;
    always_comb begin
        new_entry       = '0;
        new_entry.valid = gnt_any;
        new_entry.wr    = sel_wr;
        new_entry.ch    = grant;
        new_entry.data  = (gnt_any && !sel_wr) ? read_line : '0;
    end

    // NOTE: line storage is deliberately not reset; clearing the written bits is what makes old data invisible.
    always_ff @(posedge clk) begin
        if (gnt_any && sel_wr) begin
            mem[line_idx] <= sel_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so the pipeline shift reads pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr     <= '0;
            written <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            if (gnt_any) begin
                ptr <= (gnt_idx == PTR_W'(NCH - 1)) ? '0 : gnt_idx + PTR_W'(1);
                if (sel_wr) begin
                    written[line_idx] <= 1'b1;
                end
            end
            pipe[0] <= new_entry;
            for (int i = 1; i < LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    entry_t tail;
    logic   busy_c;

    assign tail = pipe[LATENCY-1];

    always_comb begin
        busy_c = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            busy_c = busy_c | pipe[i].valid;
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = tail.valid ? tail.ch : '0;
    assign bus.rsp_wr    = (tail.valid && tail.wr) ? tail.ch : '0;
    assign bus.busy      = busy_c;

    for (genvar g = 0; g < NCH; g++) begin : g_rsp
        assign bus.rsp_rdata[g*LINE_W +: LINE_W] = (tail.valid && tail.ch[g]) ? tail.data : '0;
    end
endmodule

// File: tb/tb_shared_mem_model.sv
// Scoreboard bench for shared_mem_model: a stimulus process predicts grants and responses
// from a queue/associative-array model, and a separate monitor compares every cycle.
module tb_shared_mem_model;
    localparam int NCH       = 2;
    localparam int ADDR_W    = 32;
    localparam int LINE_W    = 128;
    localparam int DEPTH_LG2 = 8;
    localparam int LATENCY   = 5;
    localparam int NLINES    = 1 << DEPTH_LG2;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    shared_mem_model_if #(.NCH(NCH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    shared_mem_model #(
        .NCH(NCH), .ADDR_W(ADDR_W), .LINE_W(LINE_W),
        .DEPTH_LG2(DEPTH_LG2), .LATENCY(LATENCY)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                due;
        int                ch;
        bit                wr;
        logic [LINE_W-1:0] data;
    } exp_t;

    exp_t              sb_q [$];
    logic [LINE_W-1:0] ref_mem [int];
    int                rr_ptr;

    bit                pend_valid [NCH];
    bit                pend_wr    [NCH];
    logic [ADDR_W-1:0] pend_addr  [NCH];
    logic [LINE_W-1:0] pend_data  [NCH];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] unwritten(input int idx);
        logic [LINE_W-1:0] v;
        v = '0;
`ifdef SHARED_MEM_MODEL_SCRAMBLE_EN
        for (int w = 0; w < LINE_W / 32; w++) v[w*32 +: 32] = 32'hDEADBEEF ^ 32'(idx);
`endif
        return v;
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int w = 0; w < LINE_W / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic drive();
        for (int ch = 0; ch < NCH; ch++) begin
            bus.req_valid[ch]                  = pend_valid[ch];
            bus.req_wr[ch]                     = pend_wr[ch];
            bus.req_addr[ch*ADDR_W +: ADDR_W]  = pend_addr[ch];
            bus.req_wdata[ch*LINE_W +: LINE_W] = pend_data[ch];
        end
    endtask

    task automatic issue(input int ch, input bit wr, input logic [ADDR_W-1:0] addr,
                         input logic [LINE_W-1:0] data);
        pend_valid[ch] = 1'b1;
        pend_wr[ch]    = wr;
        pend_addr[ch]  = addr;
        pend_data[ch]  = data;
        drive();
    endtask

    // One clock cycle: predict the grant, check req_ready, update the model, then drive the next cycle.
    task automatic tick();
        int   g;
        int   c;
        int   idx;
        exp_t e;
        @(negedge clk);
        #1;
        g = -1;
        if (!reset) begin
            for (int k = 0; k < NCH; k++) begin
                c = (rr_ptr + k) % NCH;
                if (g < 0 && pend_valid[c]) g = c;
            end
        end
        check("req_ready", 256'(bus.req_ready), (g < 0) ? 256'(0) : (256'(1) << g));
        if (reset) begin
            sb_q.delete();
            ref_mem.delete();
            rr_ptr = 0;
        end else if (g >= 0) begin
            idx    = int'(pend_addr[g] >> 4) % NLINES;
            e.due  = cyc + LATENCY;
            e.ch   = g;
            e.wr   = pend_wr[g];
            if (pend_wr[g]) begin
                ref_mem[idx] = pend_data[g];
                e.data       = '0;
            end else begin
                e.data = ref_mem.exists(idx) ? ref_mem[idx] : unwritten(idx);
            end
            sb_q.push_back(e);
            rr_ptr        = (g + 1) % NCH;
            pend_valid[g] = 1'b0;
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    // Monitor: compares every output once per cycle against the scoreboard queue.
    logic [NCH-1:0]        exp_valid;
    logic [NCH-1:0]        exp_wr;
    logic [NCH*LINE_W-1:0] exp_data;
    logic                  exp_busy;
    exp_t                  mon_e;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            exp_busy = 1'b0;
            foreach (sb_q[j]) begin
                if (sb_q[j].due >= cyc && sb_q[j].due - LATENCY < cyc) exp_busy = 1'b1;
            end
            check("busy", 256'(bus.busy), 256'(exp_busy));
            exp_valid = '0;
            exp_wr    = '0;
            exp_data  = '0;
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                mon_e                                = sb_q.pop_front();
                exp_valid[mon_e.ch]                  = 1'b1;
                exp_wr[mon_e.ch]                     = mon_e.wr;
                exp_data[mon_e.ch*LINE_W +: LINE_W]  = mon_e.data;
            end
            check("rsp_valid", 256'(bus.rsp_valid), 256'(exp_valid));
            check("rsp_wr", 256'(bus.rsp_wr), 256'(exp_wr));
            check("rsp_rdata", 256'(bus.rsp_rdata), 256'(exp_data));
        end
    end

    logic [ADDR_W-1:0] addr;

    initial begin
        checks = 0;
        errors = 0;
        rr_ptr = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            pend_valid[ch] = 1'b0;
            pend_wr[ch]    = 1'b0;
            pend_addr[ch]  = '0;
            pend_data[ch]  = '0;
        end
        reset = 1'b1;
        drive();
        tick();
        tick();
        reset = 1'b0;

        // Both channels contend: six grants alternating 0,1,0,1,0,1.
        issue(0, 1'b0, 32'h0000_0100, '0);
        issue(1, 1'b0, 32'h0000_0200, '0);
        for (int n = 0; n < 6; n++) begin
            if (n >= 1 && n <= 4) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    if (!pend_valid[ch]) issue(ch, 1'b0, 32'h0000_0300 + 32'(n * 16), '0);
                end
            end
            tick();
        end

        // Write on ch0 then read-after-write on ch1 of the same line.
        issue(0, 1'b1, 32'h0000_0040, 128'h0123456789ABCDEF0123456789ABCDEF);
        issue(1, 1'b0, 32'h0000_0040, '0);
        tick();
        tick();

        // Never-written line.
        issue(0, 1'b0, 32'h0000_0080, '0);
        tick();

        // Address aliasing modulo the storage size.
        issue(1, 1'b1, 32'h0000_0010, {16{8'hA5}});
        tick();
        issue(0, 1'b0, 32'h0000_1010, '0);
        tick();
        for (int n = 0; n < 6; n++) tick();

        // Reset while a read is in flight drops it and forgets written lines.
        issue(0, 1'b0, 32'h0000_0040, '0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int n = 0; n < 8; n++) tick();
        issue(0, 1'b0, 32'h0000_0040, '0);
        tick();

        // Single channel streaming at one request per cycle.
        for (int n = 0; n < 8; n++) begin
            issue(1, 1'b0, 32'h0000_0500 + 32'(n * 16), '0);
            tick();
        end
        for (int n = 0; n < 6; n++) tick();

        // Randomized mixed traffic over a small, aliased line set.
        for (int n = 0; n < 300; n++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (!pend_valid[ch] && $urandom_range(0, 9) < 6) begin
                    addr        = $urandom;
                    addr[11:4]  = 8'($urandom_range(0, 15));
                    issue(ch, 1'($urandom_range(0, 1)), addr, rand_line());
                end
            end
            if (n == 150) reset = 1'b1;
            tick();
            reset = 1'b0;
        end

        for (int ch = 0; ch < NCH; ch++) pend_valid[ch] = 1'b0;
        drive();
        for (int n = 0; n < 3 * LATENCY && sb_q.size() > 0; n++) tick();
        tick();
        check("drain", 256'(sb_q.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
